sodor_instr_gen: RTL and testbench
==================================

Name: sodor_instr_gen

Overview:
- Synthesizable, parametrised random instruction stimulus generator for Sodor 5-stage core/model co-simulation.
- Replaces ad-hoc per-test `$urandom` benches.
- Emits a deterministic, seeded stream of RV32I R-type, I-type ALU, load and store instructions over a valid/ready interface into the shared imem-response path of `sodor5_verif`.
- Stream shape: NOP warm-up, fixed-length body, NOP drain, then a done flag.

Parameters:
- SEED, 32'h000003F2, reset LFSR state; value 0 is replaced by 32'h00000001.
- NUM_INSTR, 100, body instructions emitted per run (1..65535).
- WARMUP_NOPS, 3, NOPs emitted before the body.
- DRAIN_NOPS, 5, NOPs emitted after the body so the pipeline empties.
- DMEM_BYTES, 64, data-memory window in bytes (power of 2); load/store offsets are confined to it.
- CNT_W, 16, width of the instruction counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a run from IDLE or DONE
- mode_en  in  4  enabled classes: [0] R, [1] I-ALU, [2] LOAD, [3] STORE
- instr_ready  in  1  consumer accepts instr this cycle
- instr_valid  out  1  instr is valid
- instr  out  32  instruction word
- count  out  CNT_W  body instructions accepted so far
- busy  out  1  in WARMUP, GEN or DRAIN
- done  out  1  run complete; held until the next start

Behaviour:
- Reset values: instr_valid=0, instr=32'h00000013, count=0, busy=0, done=0, state=IDLE, lfsr=SEED.
- Reset is asynchronous; asserting it mid-run aborts the run immediately to the reset values.
- FSM states: IDLE, WARMUP, GEN, DRAIN, DONE.
  - IDLE/DONE + start -> WARMUP. On this transition: done=0, count=0; lfsr is not reseeded.
  - WARMUP -> GEN after WARMUP_NOPS accepted NOPs. If WARMUP_NOPS=0, go straight to GEN.
  - GEN -> DRAIN when the NUM_INSTR-th body instruction is accepted.
  - DRAIN -> DONE after DRAIN_NOPS accepted NOPs.
  - start while busy is ignored.
- Handshake:
  - A transfer occurs when instr_valid && instr_ready.
  - While valid && !ready, instr is held stable.
  - The next word appears the cycle after a transfer (registered output, zero bubbles with ready held high).
  - instr_valid=1 in WARMUP, GEN and DRAIN; 0 in IDLE and DONE.
- LFSR:
  - 32-bit Galois, mask 32'h80200003, shift right.
  - Advances exactly once per accepted GEN instruction only. NOPs do not advance it.
  - The body word is decoded from current state s.
- Field slicing from s:
  - rd=s[11:7], f3=s[14:12], rs1=s[19:15], rs2=s[24:20], imm=s[31:20], alt=s[30], cls=s[1:0].
- Class selection:
  - If class cls is not enabled in mode_en, rotate upward (mod 4) to the next enabled class.
  - If mode_en==0, emit NOP. The NOP still counts as a body instruction.
- R-type (opcode 0110011):
  - funct7 = 7'b0100000 iff alt && (f3==0 || f3==5); otherwise funct7 = 0. This yields SUB/SRA.
- I-ALU (opcode 0010011):
  - f3==1: imm &= 12'h01F.
  - f3==5: imm &= 12'h41F.
- LOAD (opcode 0000011):
  - f3 mapped from s[14:12] via the table {0,1,2,4,5,0,1,2}.
  - rs1 = x0.
  - imm = s[31:20] & (DMEM_BYTES-1), aligned to access size: halfword clears bit0; word clears bits1:0.
- STORE (opcode 0100011):
  - f3 = s[13:12] mod 3, i.e. {0,1,2,0}.
  - rs1 = x0; rs2 = s[24:20].
  - imm masked and aligned as for LOAD, split across fields imm[11:5] and imm[4:0].
- count:
  - Increments on each accepted GEN transfer only.
  - Saturates at 2^CNT_W−1. NUM_INSTR larger than that is a parameter error (elaboration assert).
- done asserts the cycle after the last DRAIN NOP is accepted.

Optional Feature:
- Macro: SODOR_GEN_HAZARD_EN.
- Defined:
  - Keep a 5-bit register last_rd, updated on each accepted body instruction.
  - On every body instruction whose count[1:0]==2'b11, force rs1=last_rd; this applies to R and I classes only.
  - Purpose: produce guaranteed RAW hazards to exercise the bypass paths.
- Undefined: fields are independent; no last_rd register exists.

Decomposition:
- Package sodor_gen_pkg contains:
  - opcode constants: OPC_R, OPC_I, OPC_LOAD, OPC_STORE.
  - NOP_INSTR = 32'h00000013.
  - LFSR_MASK.
  - class enum: CLS_R, CLS_I, CLS_LD, CLS_ST.
  - state enum.
  - funct3 load map.
- Sub-module sodor_gen_lfsr: parametrised width and mask, with inputs clk, reset_n, seed, adv and output state.
- Encoding is a combinational function in the package.

Test Plan:
- Defaults, mode_en=4'b0001, ready=1, start pulse -> 3×32'h00000013, then 100 R-type words (opcode 0110011, funct7 ∈ {0, 0x20}), 5 NOPs; done=1 and count=100 at the end.
- ready toggling 1010… during GEN -> instr stable while stalled; the sequence is identical to the ready=1 run (compare against a golden list).
- mode_en=4'b0100, DMEM_BYTES=64 -> every word has opcode 0000011, rs1=0, imm<64, LW offsets ≡0 mod 4, LH/LHU offsets even.
- mode_en=4'b0000 -> body of 100 NOPs; count=100.
- reset_n low for 1 cycle mid-GEN at count=40 -> outputs return to reset values immediately; a fresh start reproduces the first word of the original run.
- With SODOR_GEN_HAZARD_EN, mode_en=4'b0001 -> the body instruction with count[1:0]==3 has rs1 equal to the previous word's rd, for all 25 occurrences.

Source files
------------

// File: rtl/sodor_gen_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sodor_gen_pkg : constants, state codes and instruction encoder shared   |
// |                 by the Sodor random instruction generator.              |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
package sodor_gen_pkg;

   localparam logic [6:0]  OPC_R     = 7'b0110011;
   localparam logic [6:0]  OPC_I     = 7'b0010011;
   localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
   localparam logic [6:0]  OPC_STORE = 7'b0100011;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam logic [31:0] LFSR_MASK = 32'h80200003;

   typedef enum logic [1:0] {
      CLS_R  = 2'd0,
      CLS_I  = 2'd1,
      CLS_LD = 2'd2,
      CLS_ST = 2'd3
   } gen_cls_e;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WARMUP = 3'd1;
   localparam logic [2:0] ST_GEN    = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // Load funct3 indexed by s[14:12]; entry 0 in the LSBs: LB,LH,LW,LBU,LHU,LB,LH,LW
   localparam logic [23:0] LD_F3_MAP = {3'd2, 3'd1, 3'd0, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
   endfunction

   // First enabled class at or above raw, wrapping mod 4
   function automatic gen_cls_e pick_cls(input logic [1:0] raw, input logic [3:0] en);
      logic [1:0] pick;
      logic [1:0] idx;
      pick = raw;
      for (int k = 3; k >= 0; k--) begin
         idx = raw + 2'(k);
         if (en[idx]) pick = idx;
      end
      return gen_cls_e'(pick);
   endfunction

   function automatic logic [11:0] ls_align(input logic [11:0] off, input logic [1:0] size);
      case (size)
         2'd1:    return {off[11:1], 1'b0};
         2'd2:    return {off[11:2], 2'b00};
         default: return off;
      endcase
   endfunction

   function automatic logic [31:0] gen_encode(
      input logic [31:0] s,
      input logic [3:0]  en,
      input logic [11:0] dmask,
      input logic        frc_rs1,
      input logic [4:0]  last_rd
   );
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3, f3_ls;
      logic [11:0] imm, off;
      logic [6:0]  f7;
      rd  = s[11:7];
      rs1 = frc_rs1 ? last_rd : s[19:15];
      rs2 = s[24:20];
      f3  = s[14:12];
      imm = s[31:20];
      off = s[31:20] & dmask;
      f7  = (s[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'b0100000 : 7'b0000000;
      gen_encode = NOP_INSTR;
      if (en != 4'b0000) begin
         case (pick_cls(s[1:0], en))
            CLS_R: gen_encode = {f7, rs2, rs1, f3, rd, OPC_R};
            CLS_I: begin
               if (f3 == 3'd1)      imm = imm & 12'h01F;
               else if (f3 == 3'd5) imm = imm & 12'h41F;
               gen_encode = {imm, rs1, f3, rd, OPC_I};
            end
            CLS_LD: begin
               f3_ls = LD_F3_MAP[3*s[14:12] +: 3];
               off   = ls_align(off, f3_ls[1:0]);
               gen_encode = {off, 5'd0, f3_ls, rd, OPC_LOAD};
            end
            default: begin
               f3_ls = {1'b0, (s[13:12] == 2'd3) ? 2'd0 : s[13:12]};
               off   = ls_align(off, f3_ls[1:0]);
               gen_encode = {off[11:5], rs2, 5'd0, f3_ls, off[4:0], OPC_STORE};
            end
         endcase
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/sodor_gen_lfsr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sodor_gen_lfsr : right-shifting Galois LFSR, advances when adv is high. |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module sodor_gen_lfsr
   import sodor_gen_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] MASK  = LFSR_MASK
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] seed,
   input  logic             adv,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_q, state_d, seed_nz;

   // An all-zero state would lock up the LFSR
   assign seed_nz = (seed == '0) ? WIDTH'(1) : seed;

   always_comb begin
      state_d = state_q;
      if (adv) state_d = (state_q >> 1) ^ ({WIDTH{state_q[0]}} & MASK);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= seed_nz;
      else          state_q <= state_d;
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/sodor_instr_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sodor_instr_gen : seeded RV32I stimulus stream (NOP warm-up, body,      |
// |   NOP drain) over valid/ready. Option macro: SODOR_GEN_HAZARD_EN.       |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module sodor_instr_gen
   import sodor_gen_pkg::*;
#(
   parameter logic [31:0] SEED        = 32'h000003F2,
   parameter int          NUM_INSTR   = 100,
   parameter int          WARMUP_NOPS = 3,
   parameter int          DRAIN_NOPS  = 5,
   parameter int          DMEM_BYTES  = 64,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       mode_en,
   input  logic             instr_ready,
   output logic             instr_valid,
   output logic [31:0]      instr,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done
);

   localparam int               NOP_W      = 16;
   localparam logic [NOP_W-1:0] WARM_LAST  = NOP_W'(WARMUP_NOPS - 1);
   localparam logic [NOP_W-1:0] DRAIN_LAST = NOP_W'(DRAIN_NOPS - 1);
   localparam logic [CNT_W-1:0] BODY_LAST  = CNT_W'(NUM_INSTR - 1);
   localparam logic [11:0]      DMEM_MASK  = 12'(DMEM_BYTES - 1);

   if (NUM_INSTR < 1 || NUM_INSTR > (2**CNT_W) - 1) begin : g_bad_num_instr
      $error("NUM_INSTR must lie in 1..2^CNT_W-1");
   end
   if (DMEM_BYTES < 1 || DMEM_BYTES > 4096 || (DMEM_BYTES & (DMEM_BYTES - 1)) != 0) begin : g_bad_dmem
      $error("DMEM_BYTES must be a power of 2 no larger than 4096");
   end

   logic [2:0]       state_q, state_d;
   logic [NOP_W-1:0] nop_cnt_q, nop_cnt_d;
   logic [CNT_W-1:0] count_q, count_d, count_inc;
   logic             valid_q, valid_d, done_q, done_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      lfsr_s, body_first, body_nxt;
   logic             lfsr_adv, xfer, frc_nxt;
   logic [4:0]       lrd_nxt;

   sodor_gen_lfsr #(.WIDTH(32), .MASK(LFSR_MASK)) u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .seed    (SEED),
      .adv     (lfsr_adv),
      .state   (lfsr_s)
   );

   assign xfer      = valid_q && instr_ready;
   assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

`ifdef SODOR_GEN_HAZARD_EN
   logic [4:0] last_rd_q, last_rd_d;

   always_comb begin
      last_rd_d = last_rd_q;
      if (xfer && state_q == ST_GEN) last_rd_d = lfsr_s[11:7];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last_rd_q <= 5'd0;
      else          last_rd_q <= last_rd_d;
   end

   assign frc_nxt = (count_inc[1:0] == 2'b11);
   assign lrd_nxt = last_rd_d;
`else
   assign frc_nxt = 1'b0;
   assign lrd_nxt = 5'd0;
`endif

   // Output is registered, so the word after a body transfer is decoded from the advanced LFSR
   assign body_first = gen_encode(lfsr_s, mode_en, DMEM_MASK, 1'b0, 5'd0);
   assign body_nxt   = gen_encode(lfsr_step(lfsr_s), mode_en, DMEM_MASK, frc_nxt, lrd_nxt);

   always_comb begin
      state_d   = state_q;
      nop_cnt_d = nop_cnt_q;
      count_d   = count_q;
      valid_d   = valid_q;
      done_d    = done_q;
      instr_d   = instr_q;
      lfsr_adv  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               done_d    = 1'b0;
               count_d   = '0;
               nop_cnt_d = '0;
               valid_d   = 1'b1;
               if (WARMUP_NOPS == 0) begin
                  state_d = ST_GEN;
                  instr_d = body_first;
               end else begin
                  state_d = ST_WARMUP;
                  instr_d = NOP_INSTR;
               end
            end
         end
         ST_WARMUP: begin
            if (xfer) begin
               if (nop_cnt_q == WARM_LAST) begin
                  state_d   = ST_GEN;
                  nop_cnt_d = '0;
                  instr_d   = body_first;
               end else begin
                  nop_cnt_d = nop_cnt_q + 1'b1;
               end
            end
         end
         ST_GEN: begin
            if (xfer) begin
               lfsr_adv = 1'b1;
               count_d  = count_inc;
               if (count_q == BODY_LAST) begin
                  instr_d = NOP_INSTR;
                  if (DRAIN_NOPS == 0) begin
                     state_d = ST_DONE;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end else begin
                  instr_d = body_nxt;
               end
            end
         end
         ST_DRAIN: begin
            if (xfer) begin
               if (nop_cnt_q == DRAIN_LAST) begin
                  state_d   = ST_DONE;
                  nop_cnt_d = '0;
                  valid_d   = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  nop_cnt_d = nop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         nop_cnt_q <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         instr_q   <= NOP_INSTR;
      end else begin
         state_q   <= state_d;
         nop_cnt_q <= nop_cnt_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         instr_q   <= instr_d;
      end
   end

   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign count       = count_q;
   assign done        = done_q;
   assign busy        = (state_q == ST_WARMUP) || (state_q == ST_GEN) || (state_q == ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_sodor_instr_gen.sv
`default_nettype none
// Directed bench for sodor_instr_gen: hand-computed vector table plus full-stream sequences.
module tb_sodor_instr_gen;

   localparam logic [31:0] NOP = 32'h00000013;
`ifdef SODOR_GEN_HAZARD_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n, start, instr_ready, instr_valid, busy, done;
   logic [3:0]  mode_en;
   logic [31:0] instr;
   logic [15:0] count;

   int checks   = 0;
   int failures = 0;
   logic [31:0] got[$];
   logic [31:0] expq[$];
   logic [31:0] golden[$];

   typedef struct {
      logic [3:0]  mode;
      logic [31:0] w0, w1, w2;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   sodor_instr_gen dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .mode_en     (mode_en),
      .instr_ready (instr_ready),
      .instr_valid (instr_valid),
      .instr       (instr),
      .count       (count),
      .busy        (busy),
      .done        (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
   endfunction

   function automatic logic [31:0] m_enc(input logic [31:0] s, input logic [3:0] mode,
                                         input bit frc, input logic [4:0] lrd);
      logic [2:0]  f3, lf3;
      logic [1:0]  sf3;
      logic [4:0]  rs1;
      logic [11:0] imm, off;
      int c;
      if (mode == 4'b0000) return NOP;
      f3  = s[14:12];
      imm = s[31:20];
      off = s[31:20] & 12'h03F;
      rs1 = frc ? lrd : s[19:15];
      c = int'(s[1:0]);
      while (!mode[c]) c = (c + 1) % 4;
      if (c == 0) begin
         return {(s[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00,
                 s[24:20], rs1, f3, s[11:7], 7'h33};
      end else if (c == 1) begin
         if (f3 == 3'd1) imm = imm & 12'h01F;
         if (f3 == 3'd5) imm = imm & 12'h41F;
         return {imm, rs1, f3, s[11:7], 7'h13};
      end else if (c == 2) begin
         case (f3)
            3'd3:    lf3 = 3'd4;
            3'd4:    lf3 = 3'd5;
            3'd5:    lf3 = 3'd0;
            3'd6:    lf3 = 3'd1;
            3'd7:    lf3 = 3'd2;
            default: lf3 = f3;
         endcase
         if (lf3 == 3'd1 || lf3 == 3'd5) off[0] = 1'b0;
         if (lf3 == 3'd2) off[1:0] = 2'b00;
         return {off, 5'd0, lf3, s[11:7], 7'h03};
      end else begin
         sf3 = (s[13:12] == 2'd3) ? 2'd0 : s[13:12];
         if (sf3 == 2'd1) off[0] = 1'b0;
         if (sf3 == 2'd2) off[1:0] = 2'b00;
         return {off[11:5], s[24:20], 5'd0, 1'b0, sf3, off[4:0], 7'h23};
      end
   endfunction

   task automatic build_exp(input logic [3:0] mode);
      logic [31:0] s;
      logic [4:0]  lrd;
      s   = 32'h000003F2;
      lrd = 5'd0;
      expq.delete();
      repeat (3) expq.push_back(NOP);
      for (int i = 0; i < 100; i++) begin
         expq.push_back(m_enc(s, mode, HZ && (i % 4 == 3), lrd));
         lrd = s[11:7];
         s   = m_step(s);
      end
      repeat (5) expq.push_back(NOP);
   endtask

   task automatic hard_reset();
      instr_ready = 1'b0;
      start       = 1'b0;
      reset_n     = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic do_start();
      @(negedge clk);
      instr_ready = 1'b0;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Accept n words; toggle=1 drives ready 0,1,0,1...; start pulses on cycle start_at
   task automatic collect(input int n, input bit toggle, input int start_at);
      int          cyc;
      bit          ph, stalled;
      logic [31:0] held;
      cyc = 0; ph = 1'b0; stalled = 1'b0; held = '0;
      got.delete();
      while (got.size() < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (stalled) chk("stall_hold", instr, held);
         start       = (cyc == start_at);
         instr_ready = toggle ? ph : 1'b1;
         ph          = ~ph;
         if (instr_valid && instr_ready) begin
            got.push_back(instr);
            stalled = 1'b0;
         end else if (instr_valid) begin
            stalled = 1'b1;
            held    = instr;
         end
      end
      if (got.size() < n) chk("collect_timeout", got.size(), n);
   endtask

   task automatic check_end(input string tag);
      @(negedge clk);
      chk({tag, "_done"},  {31'b0, done},        32'd1);
      chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
      chk({tag, "_busy"},  {31'b0, busy},        32'd0);
      chk({tag, "_count"}, {16'b0, count},       32'd100);
   endtask

   initial begin
      bit   ok;
      int   nhz;
      logic [31:0] w;
      mode_en = 4'b0001;
      vecs[0] = '{4'b0001, 32'h000003B3, 32'h000001B3, 32'h002000B3};
      vecs[1] = '{4'b0010, 32'h00000393, 32'h00000193, 32'h80200093};
      vecs[2] = '{4'b0100, 32'h00000383, 32'h00000183, 32'h00200083};
      vecs[3] = '{4'b1000, 32'h00000023, 32'h00000023, 32'h00200123};
      vecs[4] = '{4'b0000, NOP,          NOP,          NOP};
      vecs[5] = '{4'b1111, 32'h00000383, 32'h00000193, 32'h00200123};
      vecs[6] = '{4'b0011, 32'h000003B3, 32'h00000193, 32'h002000B3};

      instr_ready = 1'b0;
      start       = 1'b0;
      reset_n     = 1'b0;
      @(negedge clk);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr,                NOP);
      chk("rst_count", {16'b0, count},       32'd0);
      chk("rst_busy",  {31'b0, busy},        32'd0);
      chk("rst_done",  {31'b0, done},        32'd0);

      for (int v = 0; v < 7; v++) begin
         hard_reset();
         mode_en = vecs[v].mode;
         do_start();
         chk("vec_busy", {31'b0, busy}, 32'd1);
         collect(6, 1'b0, -1);
         chk("vec_warm", got[0], NOP);
         chk("vec_w0",   got[3], vecs[v].w0);
         chk("vec_w1",   got[4], vecs[v].w1);
         chk("vec_w2",   got[5], vecs[v].w2);
      end

      // Full R-only run with ready held high
      hard_reset();
      mode_en = 4'b0001;
      build_exp(4'b0001);
      do_start();
      collect(108, 1'b0, -1);
      for (int i = 0; i < 108; i++) chk("r_stream", got[i], expq[i]);
      for (int i = 3; i < 103; i++) begin
         ok = (got[i][6:0] == 7'h33) && (got[i][31:25] == 7'h00 || got[i][31:25] == 7'h20);
         chk("r_format", {31'b0, ok}, 32'd1);
      end
      check_end("r_run");
      golden = got;

      // Same run with ready toggling and a start pulse while busy
      hard_reset();
      do_start();
      collect(108, 1'b1, 30);
      for (int i = 0; i < 108; i++) chk("toggle_vs_golden", got[i], golden[i]);
      check_end("toggle_run");

      // Load-only run
      hard_reset();
      mode_en = 4'b0100;
      build_exp(4'b0100);
      do_start();
      collect(108, 1'b0, -1);
      for (int i = 0; i < 108; i++) chk("ld_stream", got[i], expq[i]);
      for (int i = 3; i < 103; i++) begin
         w  = got[i];
         ok = (w[6:0] == 7'h03) && (w[19:15] == 5'd0) && (w[31:20] < 12'd64);
         if (w[13:12] == 2'd2) ok = ok && (w[21:20] == 2'b00);
         if (w[13:12] == 2'd1) ok = ok && (w[20] == 1'b0);
         chk("ld_props", {31'b0, ok}, 32'd1);
      end
      check_end("ld_run");

      // No classes enabled: body is all NOPs but still counted
      hard_reset();
      mode_en = 4'b0000;
      do_start();
      collect(108, 1'b0, -1);
      for (int i = 0; i < 108; i++) chk("nop_body", got[i], NOP);
      check_end("nop_run");

      // Asynchronous reset mid-GEN at count 40
      hard_reset();
      mode_en = 4'b0001;
      do_start();
      collect(43, 1'b0, -1);
      @(posedge clk);
      #1;
      chk("mid_count", {16'b0, count}, 32'd40);
      reset_n = 1'b0;
      #1;
      chk("abort_valid", {31'b0, instr_valid}, 32'd0);
      chk("abort_instr", instr,                NOP);
      chk("abort_count", {16'b0, count},       32'd0);
      chk("abort_busy",  {31'b0, busy},        32'd0);
      chk("abort_done",  {31'b0, done},        32'd0);
      @(negedge clk);
      reset_n     = 1'b1;
      instr_ready = 1'b0;
      do_start();
      collect(4, 1'b0, -1);
      chk("restart_first", got[3], golden[3]);

`ifdef SODOR_GEN_HAZARD_EN
      nhz = 0;
      for (int i = 3; i < 103; i++) begin
         if ((i - 3) % 4 == 3) begin
            nhz++;
            chk("hazard_rs1", {27'b0, golden[i][19:15]}, {27'b0, golden[i-1][11:7]});
         end
      end
      chk("hazard_occurrences", nhz, 32'd25);
`else
      nhz = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
